// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the MIPS register file and its scoreboard.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_NRD      = 2;
  localparam int RF_ZERO_IDX = 0;

  // LSB position of read port 'port' inside a packed bus of 'width'-bit lanes.
  function automatic int rd_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: decode reserves, writeback releases.
// Exposes both the flopped vector and its next-state value for same-cycle reads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  output logic [DEPTH-1:0]  o_busy,
  output logic [DEPTH-1:0]  o_busy_nxt
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Release first so a same-cycle reserve of that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[RF_ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy     = r_busy;
  assign o_busy_nxt = w_busy_nxt;

endmodule

// File: rtl/mips_regfile.sv
// Flop-based multi-port register file with write-first bypass, optional hardwired r0
// and a pending-write scoreboard. Reads are registered (1 cycle).
module mips_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [DEPTH-1:0]      busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr_en;

  assign w_wr_en = we && !(ZR && (wa == ZIDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (rsv_en),
    .i_set_addr(rsv_addr),
    .i_clr_en  (we),
    .i_clr_addr(wa),
    .o_busy    (busy_vec),
    .o_busy_nxt(w_busy_nxt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] r_dat;
    logic              r_bsy;

    assign w_ra = rd_addr[rd_lsb(g, ADDR_W) +: ADDR_W];

    // Busy uses next-state so it agrees with the bypassed data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dat <= '0;
        r_bsy <= 1'b0;
      end else begin
        if (ZR && (w_ra == ZIDX))          r_dat <= '0;
        else if (w_wr_en && (wa == w_ra))  r_dat <= wd;
        else                               r_dat <= r_mem[w_ra];
        r_bsy <= w_busy_nxt[w_ra];
      end
    end

    assign rd_data[rd_lsb(g, DATA_W) +: DATA_W] = r_dat;
    assign rd_busy[g] = r_bsy;
  end

endmodule
